pan_scheduler: RTL and testbench

Sequences the per-voice stereo placement codes consumed by the three-voice stereo conditioner, moving voices a/b/c across left/centre/right on beat or note events. Registered outputs change only on sample boundaries. Direct left<->right swaps pass through a both-channels crossover hold so the mixer never sees a hard jump. Sits between the beat generator / note players and the stereo conditioner, driving its `stereo_data_*` and `stereo_on` inputs.

---
 rtl/pan_scheduler_pkg.sv | 64 ++++++
 rtl/pan_scheduler_if.sv | 26 ++
 rtl/pan_voice_fsm.sv | 92 +++++++++
 rtl/pan_scheduler.sv | 98 +++++++++
 tb/tb_pan_scheduler.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/pan_scheduler_pkg.sv
// Shared constants and helpers for the stereo pan scheduler.
package pan_scheduler_pkg;

  localparam int NUM_VOICES = 3;

  localparam logic [1:0] PAN_L = 2'b10;
  localparam logic [1:0] PAN_C = 2'b11;
  localparam logic [1:0] PAN_R = 2'b01;

  typedef enum logic [1:0] {
    MODE_FIXED    = 2'b00,
    MODE_ROTATE   = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_RANDOM   = 2'b11
  } mode_e;

  typedef enum logic {ST_SETTLED, ST_XFADE} voice_st_e;

  localparam logic [7:0] LFSR_SEED = 8'h01;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;  // bits 7,5,4,3

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], ^(l & LFSR_TAPS)};
  endfunction

  function automatic logic [1:0] rand_code(input logic [1:0] b);
    case (b)
      2'b00:   return PAN_L;
      2'b10:   return PAN_R;
      default: return PAN_C;
    endcase
  endfunction

  function automatic logic [1:0] home_code(input int v);
    if (v == 0) return PAN_L;
    else if (v == 1) return PAN_C;
    else return PAN_R;
  endfunction

  function automatic logic is_end(input logic [1:0] c);
    return (c == PAN_L) || (c == PAN_R);
  endfunction

  function automatic logic [1:0] rotate_code(input logic [1:0] c);
    case (c)
      PAN_L:   return PAN_C;
      PAN_C:   return PAN_R;
      default: return PAN_L;
    endcase
  endfunction

  // Returns {new_dir, new_code}; dir 1 = toward right. An end position
  // forces the step away from it regardless of the stored direction.
  function automatic logic [2:0] pp_step(input logic [1:0] c, input logic d);
    logic       eff;
    logic [1:0] nc;
    logic       nd;
    eff = (c == PAN_R) ? 1'b0 : (c == PAN_L) ? 1'b1 : d;
    nc  = is_end(c) ? PAN_C : (eff ? PAN_R : PAN_L);
    nd  = (nc == PAN_R) ? 1'b0 : (nc == PAN_L) ? 1'b1 : eff;
    return {nd, nc};
  endfunction

endpackage

// File: rtl/pan_scheduler_if.sv
// Event inputs and stereo-code outputs of the pan scheduler.
interface pan_scheduler_if;
  logic       sample_tick;
  logic       beat;
  logic [1:0] mode;
  logic       stereo_en;
  logic       note_start_a;
  logic       note_start_b;
  logic       note_start_c;
  logic [1:0] stereo_data_a;
  logic [1:0] stereo_data_b;
  logic [1:0] stereo_data_c;
  logic       stereo_on;

  modport master (
    output sample_tick, beat, mode, stereo_en,
    output note_start_a, note_start_b, note_start_c,
    input  stereo_data_a, stereo_data_b, stereo_data_c, stereo_on
  );

  modport slave (
    input  sample_tick, beat, mode, stereo_en,
    input  note_start_a, note_start_b, note_start_c,
    output stereo_data_a, stereo_data_b, stereo_data_c, stereo_on
  );
endinterface

// File: rtl/pan_voice_fsm.sv
// One voice: target register, SETTLED/XFADE FSM and crossover counter.
// Outputs only move on sample_tick; L<->R moves hold centre for XFADE_TICKS.
module pan_voice_fsm
  import pan_scheduler_pkg::*;
#(
  parameter logic [1:0] HOME        = PAN_C,
  parameter int         XFADE_TICKS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_tick,
  input  logic       clear,
  input  logic       load,
  input  logic [1:0] load_code,
  output logic [1:0] target,
  output logic [1:0] data
);

  localparam logic [7:0] XT = 8'(XFADE_TICKS);

  voice_st_e  st, st_n;
  logic [7:0] cnt, cnt_n;
  logic [1:0] dst, dst_n;
  logic [1:0] target_n, data_n;

  // State register; async reset drops straight to home.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st     <= ST_SETTLED;
      cnt    <= '0;
      dst    <= HOME;
      target <= HOME;
      data   <= HOME;
    end else begin
      st     <= st_n;
      cnt    <= cnt_n;
      dst    <= dst_n;
      target <= target_n;
      data   <= data_n;
    end
  end

  // Retarget loads, commit on tick, crossover counting and restart rules.
  always_comb begin
    st_n     = st;
    cnt_n    = cnt;
    dst_n    = dst;
    target_n = target;
    data_n   = data;
    if (load) target_n = load_code;
    if (clear) begin
      st_n     = ST_SETTLED;
      cnt_n    = '0;
      dst_n    = HOME;
      target_n = HOME;
      data_n   = HOME;
    end else if (sample_tick) begin
      case (st)
        ST_SETTLED: begin
          if (target != data) begin
            if (is_end(target) && is_end(data)) begin
              st_n   = ST_XFADE;
              data_n = PAN_C;
              cnt_n  = '0;
              dst_n  = target;
            end else begin
              data_n = target;
            end
          end
        end
        default: begin
          if (target == PAN_C) begin
            st_n   = ST_SETTLED;
            data_n = PAN_C;
            cnt_n  = '0;
          end else if (target != dst) begin
            // swung back to the other extreme: start the hold over
            dst_n = target;
            cnt_n = '0;
          end else if (cnt + 8'd1 == XT) begin
            st_n   = ST_SETTLED;
            data_n = target;
            cnt_n  = '0;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/pan_scheduler.sv
// Stereo pan scheduler: moves voices a/b/c across L/C/R on beat or note
// events for the stereo conditioner. Optional random mode with an 8-bit
// LFSR is compiled in by defining PAN_LFSR_EN; otherwise mode 11 acts as
// fixed mode and note strobes are ignored.
module pan_scheduler
  import pan_scheduler_pkg::*;
#(
  parameter int XFADE_TICKS = 4
) (
  input  logic           clk,
  input  logic           reset,
  pan_scheduler_if.slave bus
);

  logic                            stereo_on;
  logic [NUM_VOICES-1:0]           dir_r, dir_n;  // 1 = toward right
  logic [NUM_VOICES-1:0]           load;
  logic [NUM_VOICES-1:0][1:0]      tgt, data, load_code;
  logic                            clear, beat_ev;

  // falling stereo_en is only noticed on a sample tick
  assign clear   = bus.sample_tick & stereo_on & ~bus.stereo_en;
  assign beat_ev = bus.beat & stereo_on;

`ifdef PAN_LFSR_EN
  logic [7:0]            lfsr, lfsr_n;
  logic [NUM_VOICES-1:0] note;
  assign note = {bus.note_start_c, bus.note_start_b, bus.note_start_a};

  // LFSR survives stereo disable; only reset reseeds it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= lfsr_n;
  end
`endif

  // Enable tracking and ping-pong directions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stereo_on <= 1'b0;
      dir_r     <= '1;
    end else begin
      if (bus.sample_tick) stereo_on <= bus.stereo_en;
      dir_r <= dir_n;
    end
  end

  // Retarget decode per voice; random mode chains the LFSR a, b, c.
  always_comb begin
    load      = '0;
    load_code = tgt;
    dir_n     = dir_r;
`ifdef PAN_LFSR_EN
    lfsr_n    = lfsr;
`endif
    for (int v = 0; v < NUM_VOICES; v++) begin
`ifdef PAN_LFSR_EN
      if (bus.mode == MODE_RANDOM) begin
        if (stereo_on && note[v]) begin
          lfsr_n       = lfsr_next(lfsr_n);
          load[v]      = 1'b1;
          load_code[v] = rand_code(lfsr_n[1:0]);
        end
      end else
`endif
      if (beat_ev) begin
        load[v] = 1'b1;
        case (bus.mode)
          MODE_ROTATE:   load_code[v] = rotate_code(tgt[v]);
          MODE_PINGPONG: {dir_n[v], load_code[v]} = pp_step(tgt[v], dir_r[v]);
          default:       load_code[v] = home_code(v);
        endcase
      end
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    pan_voice_fsm #(
      .HOME        (home_code(v)),
      .XFADE_TICKS (XFADE_TICKS)
    ) u_voice (
      .clk         (clk),
      .reset       (reset),
      .sample_tick (bus.sample_tick),
      .clear       (clear),
      .load        (load[v]),
      .load_code   (load_code[v]),
      .target      (tgt[v]),
      .data        (data[v])
    );
  end

  assign bus.stereo_data_a = data[0];
  assign bus.stereo_data_b = data[1];
  assign bus.stereo_data_c = data[2];
  assign bus.stereo_on     = stereo_on;

endmodule

// File: tb/tb_pan_scheduler.sv
// Directed bench for pan_scheduler with hand-computed expected codes.
module tb_pan_scheduler;
  import pan_scheduler_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  pan_scheduler_if bus();

  pan_scheduler #(.XFADE_TICKS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] L = PAN_L;
  localparam logic [1:0] C = PAN_C;
  localparam logic [1:0] R = PAN_R;

  // one clock: strobes held across the next posedge, then cleared
  task automatic step(input logic t, input logic b);
    bus.sample_tick = t;
    bus.beat        = b;
    @(posedge clk);
    #1;
    bus.sample_tick  = 1'b0;
    bus.beat         = 1'b0;
    bus.note_start_a = 1'b0;
    bus.note_start_b = 1'b0;
    bus.note_start_c = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  task automatic chk(input string tag, input logic [1:0] ea, input logic [1:0] eb,
                     input logic [1:0] ec, input logic eo);
    logic [6:0] obs, exp;
    obs = {bus.stereo_data_a, bus.stereo_data_b, bus.stereo_data_c, bus.stereo_on};
    exp = {ea, eb, ec, eo};
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed a/b/c/on=%b expected=%b", tag, obs, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] pa [5];
    logic [1:0] pb [5];
    logic [1:0] pc [5];
    pa = '{C, R, C, L, C};
    pb = '{R, C, L, C, R};
    pc = '{C, L, C, R, C};

    bus.sample_tick = 0; bus.beat = 0; bus.mode = MODE_FIXED; bus.stereo_en = 0;
    bus.note_start_a = 0; bus.note_start_b = 0; bus.note_start_c = 0;

    #3 reset = 1'b1;
    #1 chk("reset", L, C, R, 1'b0);
    @(posedge clk); #1 reset = 1'b0;

    // enable, then rotate: c goes R->L through a crossover
    bus.stereo_en = 1'b1; bus.mode = MODE_ROTATE;
    step(1, 0); chk("enable", L, C, R, 1'b1);
    step(0, 1); chk("rot_beat_hold", L, C, R, 1'b1);
    step(1, 0); chk("rot_tick", C, R, C, 1'b1);
    ticks(3);   chk("c_xfade_t3", C, R, C, 1'b1);
    ticks(1);   chk("c_xfade_done", C, R, L, 1'b1);

    // fixed: everyone home, c crosses L->R
    bus.mode = MODE_FIXED;
    step(0, 1); step(1, 0); chk("fixed_home", L, C, C, 1'b1);
    ticks(3);   ticks(1);   chk("fixed_c_done", L, C, R, 1'b1);

    // two rotate beats before a tick: a L->R crossover
    bus.mode = MODE_ROTATE;
    step(0, 1); step(0, 1);
    step(1, 0); chk("a_lr_enter", C, L, C, 1'b1);
    ticks(3);   chk("a_lr_t3", C, L, C, 1'b1);
    ticks(1);   chk("a_lr_done", R, L, C, 1'b1);

    // a crosses R->L, then mid-crossover target swings back to R: restart
    step(0, 1); step(1, 0); chk("restart_enter", C, C, R, 1'b1);
    ticks(2);
    step(0, 1); step(0, 1);
    step(1, 0); chk("restart_tick", C, L, C, 1'b1);
    ticks(3);   chk("restart_t3", C, L, C, 1'b1);
    ticks(1);   chk("restart_done", R, L, C, 1'b1);

    // centre retarget during crossover settles at 11
    step(0, 1); step(1, 0);
    step(0, 1); step(1, 0); chk("centre_settle", C, R, C, 1'b1);
    bus.mode = MODE_FIXED;
    step(0, 1); step(1, 0); chk("centre_exit", L, C, C, 1'b1);
    ticks(3);   ticks(1);   chk("c_restart_done", L, C, R, 1'b1);

    // ping-pong, five beats
    bus.mode = MODE_PINGPONG;
    for (int i = 0; i < 5; i++) begin
      step(0, 1); step(1, 0);
      chk($sformatf("pingpong_%0d", i), pa[i], pb[i], pc[i], 1'b1);
    end
    bus.mode = MODE_FIXED;
    step(0, 1); step(1, 0); chk("pp_home", L, C, R, 1'b1);

    // disable during a crossover
    bus.mode = MODE_ROTATE;
    step(0, 1); step(0, 1);
    step(1, 0); chk("dis_xfade", C, L, C, 1'b1);
    ticks(1);
    bus.stereo_en = 1'b0;
    step(0, 0); chk("dis_pre", C, L, C, 1'b1);
    step(1, 0); chk("dis_home", L, C, R, 1'b0);
    step(0, 1); step(1, 0); chk("dis_beat", L, C, R, 1'b0);
    bus.stereo_en = 1'b1;
    step(1, 0); chk("reenable", L, C, R, 1'b1);

    // random mode (LFSR 01 -> 02 -> 04 -> 08)
    bus.mode = MODE_RANDOM;
    bus.note_start_a = 1'b1;
    step(0, 0); step(1, 0);
`ifdef PAN_LFSR_EN
    chk("rand_a", C, C, R, 1'b1);
`else
    chk("rand_a", L, C, R, 1'b1);
`endif
    bus.note_start_b = 1'b1; bus.note_start_c = 1'b1;
    step(0, 0); step(1, 0);
`ifdef PAN_LFSR_EN
    chk("rand_bc", C, L, C, 1'b1);
`else
    chk("rand_bc", L, C, R, 1'b1);
`endif
    step(0, 1); step(1, 0);
`ifdef PAN_LFSR_EN
    chk("rand_beat", C, L, C, 1'b1);
    ticks(2);   chk("rand_a_done", R, L, C, 1'b1);
`else
    chk("rand_beat", L, C, R, 1'b1);
    ticks(2);   chk("rand_a_done", L, C, R, 1'b1);
`endif

    // async reset mid-run, checked before the next clock edge
    #2 reset = 1'b1;
    #1 chk("reset_mid", L, C, R, 1'b0);
    @(posedge clk); #1 reset = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
